nn_bus_master: RTL and testbench

//  Driver end of the nnIntf bus: drives RW/sel/addr/din into a neural-network block and collects dout/pushout.

---
 rtl/nn_bus_master.sv | 161 ++++++++++++++++
 tb/tb_nn_bus_master.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_bus_master.sv
// nn_bus_master: drives the nnIntf bus from an in-order command queue and collects read data.
// Latency: a command pushed into an idle master is on the bus (sel=1) two cycles later; back-to-back issue is one per cycle.
// Backpressure: bus_stop holds the presented transaction; reads stall on credit (outstanding + queued responses); cmd_ready drops when the queue is full.
module nn_bus_master #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rw,
  input  logic [19:0]                 cmd_addr,
  input  logic [31:0]                 cmd_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [31:0]                 rsp_data,
  output logic                        RW,
  output logic                        sel,
  output logic [19:0]                 addr,
  output logic [31:0]                 din,
  input  logic [31:0]                 dout,
  input  logic                        bus_stop,
  input  logic                        pushout,
  output logic [$clog2(RSP_DEPTH):0]  outstanding,
  output logic                        err_unexpected,
  output logic                        idle
);

  localparam int CPW = $clog2(CMD_DEPTH);
  localparam int RPW = $clog2(RSP_DEPTH);
  localparam logic [RPW+1:0] RSP_LIM = (RPW+2)'(RSP_DEPTH);

  typedef enum logic {ST_IDLE, ST_DRIVE} state_t;

  state_t          state_q, state_d;
  logic            rw_q, rw_d;
  logic [19:0]     addr_q, addr_d;
  logic [31:0]     din_q, din_d;
  logic [CPW:0]    cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
  logic [RPW:0]    rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
  logic [RPW:0]    out_q, out_d;
  logic            err_q, err_d;

  logic            cmd_rw_mem   [CMD_DEPTH];
  logic [19:0]     cmd_addr_mem [CMD_DEPTH];
  logic [31:0]     cmd_data_mem [CMD_DEPTH];
  logic [31:0]     rsp_mem      [RSP_DEPTH];

  logic            cmd_empty, cmd_full, cmd_push, cmd_pop;
  logic            head_rw, head_ok;
  logic            accept, acc_rd, rsp_pop, rsp_push;
  logic [RPW:0]    rsp_cnt;
  logic [RPW+1:0]  used;

  // Queue status; the extra pointer bit separates full from empty.
  assign cmd_empty = (cmd_wp_q == cmd_rp_q);
  assign cmd_full  = (cmd_wp_q[CPW] != cmd_rp_q[CPW]) &&
                     (cmd_wp_q[CPW-1:0] == cmd_rp_q[CPW-1:0]);
  assign cmd_ready = ~cmd_full;
  assign cmd_push  = cmd_valid & ~cmd_full;
  assign head_rw   = cmd_rw_mem[cmd_rp_q[CPW-1:0]];

  assign rsp_cnt   = rsp_wp_q - rsp_rp_q;
  assign rsp_valid = (rsp_wp_q != rsp_rp_q);
  assign rsp_data  = rsp_mem[rsp_rp_q[RPW-1:0]];
  assign rsp_pop   = rsp_valid & rsp_ready;
  assign rsp_push  = pushout & (out_q != '0);

  // A read accepted this cycle already holds a credit; a response popped this cycle frees one.
  assign accept  = (state_q == ST_DRIVE) & ~bus_stop;
  assign acc_rd  = accept & ~rw_q;
  assign used    = {1'b0, out_q} + {1'b0, rsp_cnt}
                 + {{(RPW+1){1'b0}}, acc_rd} - {{(RPW+1){1'b0}}, rsp_pop};
  assign head_ok = ~cmd_empty & (head_rw | (used < RSP_LIM));

  assign RW             = rw_q;
  assign sel            = (state_q == ST_DRIVE);
  assign addr           = addr_q;
  assign din            = din_q;
  assign outstanding    = out_q;
  assign err_unexpected = err_q;
  assign idle           = cmd_empty & (state_q == ST_IDLE) & (out_q == '0);

  // Bus FSM: load the queue head when eligible, hold while bus_stop, drop sel when nothing can follow.
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    din_d   = din_q;
    cmd_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (head_ok) begin
          cmd_pop = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (accept) begin
          if (head_ok) cmd_pop = 1'b1;
          else         state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (cmd_pop) begin
      rw_d   = head_rw;
      addr_d = cmd_addr_mem[cmd_rp_q[CPW-1:0]];
      din_d  = cmd_data_mem[cmd_rp_q[CPW-1:0]];
    end
  end

  // Pointer, read-tracking and error bookkeeping.
  always_comb begin
    cmd_wp_d = cmd_wp_q + {{CPW{1'b0}}, cmd_push};
    cmd_rp_d = cmd_rp_q + {{CPW{1'b0}}, cmd_pop};
    rsp_wp_d = rsp_wp_q + {{RPW{1'b0}}, rsp_push};
    rsp_rp_d = rsp_rp_q + {{RPW{1'b0}}, rsp_pop};
    out_d    = out_q + {{RPW{1'b0}}, acc_rd} - {{RPW{1'b0}}, rsp_push};
    err_d    = err_q | (pushout & (out_q == '0));
  end

  // State registers with synchronous reset; reset abandons any queued or in-flight work.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      cmd_wp_q <= '0;
      cmd_rp_q <= '0;
      rsp_wp_q <= '0;
      rsp_rp_q <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      cmd_wp_q <= cmd_wp_d;
      cmd_rp_q <= cmd_rp_d;
      rsp_wp_q <= rsp_wp_d;
      rsp_rp_q <= rsp_rp_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

  // Queue storage; contents are only meaningful between the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_rw_mem[cmd_wp_q[CPW-1:0]]   <= cmd_rw;
      cmd_addr_mem[cmd_wp_q[CPW-1:0]] <= cmd_addr;
      cmd_data_mem[cmd_wp_q[CPW-1:0]] <= cmd_data;
    end
    if (rsp_push) rsp_mem[rsp_wp_q[RPW-1:0]] <= dout;
  end

endmodule

// File: tb/tb_nn_bus_master.sv
// Bench for nn_bus_master: per-cycle vector table for single write/read, then directed sequences
// for bus_stop hold, read credit, back-to-back issue, unexpected pushout and mid-operation reset.
module tb_nn_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_rw = 1'b0, rsp_ready = 1'b0, bus_stop = 1'b0;
  logic [19:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_ready, rsp_valid, RW, sel, err_unexpected, idle;
  logic [31:0] rsp_data, din, dout;
  logic [19:0] addr;
  logic [2:0]  outstanding;
  logic        pushout;

  logic        man_po = 1'b0;
  logic [31:0] man_dout = '0;
  logic        rsp_po = 1'b0;
  logic [31:0] rsp_dout = '0;

  assign pushout = man_po | rsp_po;
  assign dout    = man_po ? man_dout : rsp_dout;

  always #5 clk = ~clk;

  nn_bus_master #(.CMD_DEPTH(4), .RSP_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .RW(RW), .sel(sel), .addr(addr), .din(din), .dout(dout),
    .bus_stop(bus_stop), .pushout(pushout), .outstanding(outstanding),
    .err_unexpected(err_unexpected), .idle(idle)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // NN block model: answers each accepted read two cycles later with 0xA0000000|addr.
  typedef struct { int due; logic [31:0] d; } pend_t;
  pend_t pq[$];
  int    cyc = 0;
  int    n_rd_acc = 0;
  bit    resp_en = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    rsp_po = 1'b0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      rsp_po   = 1'b1;
      rsp_dout = pq[0].d;
      void'(pq.pop_front());
    end
    if (resp_en && !reset && sel && !bus_stop && !RW) begin
      pq.push_back('{cyc + 2, 32'hA000_0000 | {12'h0, addr}});
      n_rd_acc++;
    end
  end

  typedef struct {
    string       name;
    logic        cv, crw;
    logic [19:0] ca;
    logic [31:0] cd;
    logic        rr, bs, po;
    logic [31:0] pd;
    logic        e_sel, e_rw;
    logic [19:0] e_addr;
    logic [31:0] e_din;
    logic        e_rv;
    logic [31:0] e_rd;
    logic [2:0]  e_out;
    logic        e_idle, e_err, e_crdy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string n, input logic cv, input logic crw, input logic [19:0] ca,
                     input logic [31:0] cd, input logic rr, input logic po, input logic [31:0] pd,
                     input logic es, input logic erw, input logic [19:0] ea, input logic [31:0] ed,
                     input logic erv, input logic [31:0] erd, input logic [2:0] eo,
                     input logic eidle);
    vec_t v;
    v.name = n; v.cv = cv; v.crw = crw; v.ca = ca; v.cd = cd; v.rr = rr; v.bs = 1'b0;
    v.po = po; v.pd = pd; v.e_sel = es; v.e_rw = erw; v.e_addr = ea; v.e_din = ed;
    v.e_rv = erv; v.e_rd = erd; v.e_out = eo; v.e_idle = eidle; v.e_err = 1'b0; v.e_crdy = 1'b1;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic rw, input logic [19:0] a, input logic [31:0] d);
    int w = 0;
    while (!cmd_ready && w < 50) begin
      tick();
      w++;
    end
    if (!cmd_ready) check("push_timeout_cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_data = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pop_chk(input string nm, input logic [31:0] exp);
    check(nm, {31'b0, rsp_valid, rsp_data}, {31'b0, 1'b1, exp});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  function automatic logic [63:0] obs_all();
    return {3'b0, sel, RW, addr, din, rsp_valid, outstanding, idle, err_unexpected, cmd_ready};
  endfunction

  localparam logic [63:0] RST_OBS = {3'b0, 1'b0, 1'b0, 20'h0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] act, exp;
    logic [9:0]  pat;
    int nsel, nacc, bad, k;

    //      name          cv crw addr      data          rr po pd            sel rw addr     din           rv rd            out idle
    add("wr_push",     1, 1, 20'h10, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 20'h0,  32'h0,        0, 32'h0,        3'd0, 0);
    add("wr_drive",    0, 0, 20'h0,  32'h0,        0, 0, 32'h0,        1, 1, 20'h10, 32'hDEADBEEF, 0, 32'h0,        3'd0, 0);
    add("wr_done",     0, 0, 20'h0,  32'h0,        0, 0, 32'h0,        0, 0, 20'h0,  32'h0,        0, 32'h0,        3'd0, 1);
    add("wr_idle",     0, 0, 20'h0,  32'h0,        0, 0, 32'h0,        0, 0, 20'h0,  32'h0,        0, 32'h0,        3'd0, 1);
    add("rd_push",     1, 0, 20'h20, 32'h0,        0, 0, 32'h0,        0, 0, 20'h0,  32'h0,        0, 32'h0,        3'd0, 0);
    add("rd_drive",    0, 0, 20'h0,  32'h0,        0, 0, 32'h0,        1, 0, 20'h20, 32'h0,        0, 32'h0,        3'd0, 0);
    add("rd_accept",   0, 0, 20'h0,  32'h0,        0, 0, 32'h0,        0, 0, 20'h0,  32'h0,        0, 32'h0,        3'd1, 0);
    add("rd_wait1",    0, 0, 20'h0,  32'h0,        0, 0, 32'h0,        0, 0, 20'h0,  32'h0,        0, 32'h0,        3'd1, 0);
    add("rd_wait2",    0, 0, 20'h0,  32'h0,        0, 0, 32'h0,        0, 0, 20'h0,  32'h0,        0, 32'h0,        3'd1, 0);
    add("rd_pushout",  0, 0, 20'h0,  32'h0,        0, 1, 32'h12345678, 0, 0, 20'h0,  32'h0,        1, 32'h12345678, 3'd0, 1);
    add("rd_pop",      0, 0, 20'h0,  32'h0,        1, 0, 32'h0,        0, 0, 20'h0,  32'h0,        0, 32'h0,        3'd0, 1);

    repeat (3) tick();
    reset = 1'b0;
    check("reset_state", obs_all(), RST_OBS);

    foreach (vq[i]) begin
      cmd_valid = vq[i].cv; cmd_rw = vq[i].crw; cmd_addr = vq[i].ca; cmd_data = vq[i].cd;
      rsp_ready = vq[i].rr; bus_stop = vq[i].bs; man_po = vq[i].po; man_dout = vq[i].pd;
      tick();
      act = {3'b0, sel, sel ? RW : 1'b0, sel ? addr : 20'h0, (sel && RW) ? din : 32'h0,
             rsp_valid, outstanding, idle, err_unexpected, cmd_ready};
      exp = {3'b0, vq[i].e_sel, vq[i].e_sel ? vq[i].e_rw : 1'b0, vq[i].e_sel ? vq[i].e_addr : 20'h0,
             (vq[i].e_sel && vq[i].e_rw) ? vq[i].e_din : 32'h0,
             vq[i].e_rv, vq[i].e_out, vq[i].e_idle, vq[i].e_err, vq[i].e_crdy};
      check(vq[i].name, act, exp);
      if (vq[i].e_rv) check({vq[i].name, "_data"}, 64'(rsp_data), 64'(vq[i].e_rd));
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0; man_po = 1'b0; bus_stop = 1'b0;

    // bus_stop for four presented cycles: transaction held, accepted exactly once.
    bus_stop = 1'b1;
    push(1'b1, 20'h30, 32'hCAFE0030);
    nsel = 0; nacc = 0; bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (sel) begin
        nsel++;
        if (addr !== 20'h30 || din !== 32'hCAFE0030 || RW !== 1'b1) bad++;
        bus_stop = (nsel <= 4);
        if (!bus_stop) nacc++;
      end else begin
        bus_stop = 1'b1;
      end
      tick();
    end
    bus_stop = 1'b0;
    check("bp_sel_cycles", 64'(nsel), 64'd5);
    check("bp_accepts", 64'(nacc), 64'd1);
    check("bp_held_stable", 64'(bad), 64'd0);
    check("bp_idle_after", 64'(idle), 64'd1);

    // Six reads with no consumer: only four may be in flight or queued.
    resp_en = 1'b1; n_rd_acc = 0;
    for (int i = 0; i < 6; i++) push(1'b0, 20'h100 + 20'(i), 32'h0);
    repeat (20) tick();
    check("credit_issued", 64'(n_rd_acc), 64'd4);
    check("credit_sel_low", 64'(sel), 64'd0);
    check("credit_outstanding", 64'(outstanding), 64'd0);
    check("credit_cmd_left", 64'({cmd_ready, idle}), 64'b10);
    pop_chk("credit_pop0", 32'hA000_0100);
    pop_chk("credit_pop1", 32'hA000_0101);
    repeat (20) tick();
    check("credit_issued_after_pop", 64'(n_rd_acc), 64'd6);
    for (int i = 2; i < 6; i++) pop_chk($sformatf("credit_pop%0d", i), 32'hA000_0100 + 32'(i));
    check("credit_drained", 64'({rsp_valid, idle}), 64'b01);

    // Stall the first write so four more fill the queue, then release for back-to-back issue.
    bus_stop = 1'b1;
    for (int i = 0; i < 5; i++) push(1'b1, 20'h200 + 20'(i), 32'h5000 + 32'(i));
    check("b2b_full", 64'(cmd_ready), 64'd0);
    bus_stop = 1'b0;
    pat = '0; bad = 0; k = 0;
    for (int c = 0; c < 10; c++) begin
      if (sel) begin
        pat[c] = 1'b1;
        if (addr !== 20'h200 + 20'(k) || RW !== 1'b1 || din !== 32'h5000 + 32'(k)) bad++;
        k++;
      end
      tick();
    end
    check("b2b_pattern", 64'(pat), 64'h1F);
    check("b2b_order", 64'(bad), 64'd0);

    // pushout with nothing outstanding.
    man_po = 1'b1; man_dout = 32'h0000_0BAD;
    tick();
    man_po = 1'b0;
    check("err_set", 64'({err_unexpected, rsp_valid, outstanding}), {59'b0, 1'b1, 1'b0, 3'd0});
    repeat (5) tick();
    check("err_sticky", 64'(err_unexpected), 64'd1);

    // Reset with a queued response, a held transaction and queued commands.
    push(1'b0, 20'h300, 32'h0);
    repeat (6) tick();
    check("pre_rst_rsp", 64'(rsp_valid), 64'd1);
    bus_stop = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b1, 20'h400 + 20'(i), 32'h7000 + 32'(i));
    tick();
    check("pre_rst_drive", 64'(sel), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_state", obs_all(), RST_OBS);
    bus_stop = 1'b0;
    repeat (4) tick();
    check("rst_discard", 64'({sel, idle, rsp_valid}), 64'b010);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
